bank_responder: RTL and testbench

Single memory bank sitting on the bank side of the requester/bank crossbar. It accepts read/write requests already routed to it, performs the access on its local slice of the global address space, and returns one tagged response per request. Responses come back in order with fixed minimum latency and full backpressure. One instance per bank; `BANK_ID` selects the slice.

---
 rtl/bank_responder.sv | 179 +++++++++++++++++
 tb/tb_bank_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_responder.sv
// One crossbar bank: local memory slice, fixed-latency read pipeline and an
// in-order response FIFO with credit-based backpressure. Optional statistics via BANK_RESPONDER_STATS_EN.
module bank_responder #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 17,
    parameter int BANKS      = 5,
    parameter int BANK_ID    = 0,
    parameter int REQUESTERS = 6,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int TAG_W     = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_wr,
    output logic                  resp_err,
    output logic [TAG_W-1:0]      resp_tag,
    output logic [31:0]           stat_rd,
    output logic [31:0]           stat_wr,
    output logic [31:0]           stat_err
);

    localparam int BANK_SIZE = ((2**ADDR_WIDTH - 1) / BANKS) + 1;
    localparam int IDX_W     = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [ADDR_WIDTH:0] BASE   = (ADDR_WIDTH+1)'(BANK_ID * BANK_SIZE);
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(BANK_SIZE);
    localparam logic [PTR_W:0]      DEPTH  = (PTR_W+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH:0] offset;
    logic [IDX_W-1:0]    local_idx;
    logic                in_range;
    logic                accept;
    logic                push;
    logic                pop;

    logic [DATA_WIDTH-1:0] mem [BANK_SIZE];

    logic                  st_valid [RD_LATENCY];
    logic                  st_wr    [RD_LATENCY];
    logic                  st_err   [RD_LATENCY];
    logic [TAG_W-1:0]      st_tag   [RD_LATENCY];
    logic [DATA_WIDTH-1:0] st_data  [RD_LATENCY];

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                  fifo_wr   [FIFO_DEPTH];
    logic                  fifo_err  [FIFO_DEPTH];
    logic [TAG_W-1:0]      fifo_tag  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic [PTR_W:0]   outstanding;

    // Addresses below the base wrap to a large offset, so one compare covers both bounds.
    assign offset    = {1'b0, req_addr} - BASE;
    assign in_range  = (offset < SIZE_L);
    assign local_idx = IDX_W'(offset);

    assign pop       = resp_valid && resp_ready;
    assign req_ready = rst_n && ((outstanding < DEPTH) || pop);
    assign accept    = req_valid && req_ready;
    assign push      = st_valid[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (accept && req_wr && in_range) begin
            mem[local_idx] <= req_wdata;
        end
    end

    // Stage 0 samples memory at the accept edge; later stages only delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_wr[i]    <= 1'b0;
                st_err[i]   <= 1'b0;
                st_tag[i]   <= '0;
                st_data[i]  <= '0;
            end
        end else begin
            st_valid[0] <= accept;
            st_wr[0]    <= req_wr;
            st_err[0]   <= !in_range;
            st_tag[0]   <= req_tag;
            st_data[0]  <= (in_range && !req_wr) ? mem[local_idx] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_wr[i]    <= st_wr[i-1];
                st_err[i]   <= st_err[i-1];
                st_tag[i]   <= st_tag[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= st_data[RD_LATENCY-1];
            fifo_wr[wr_ptr]   <= st_wr[RD_LATENCY-1];
            fifo_err[wr_ptr]  <= st_err[RD_LATENCY-1];
            fifo_tag[wr_ptr]  <= st_tag[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Storage is not reset, so outputs are forced to zero whenever the FIFO is empty.
    assign resp_valid = (fifo_cnt != '0);
    assign resp_data  = resp_valid ? fifo_data[rd_ptr] : '0;
    assign resp_wr    = resp_valid ? fifo_wr[rd_ptr]   : 1'b0;
    assign resp_err   = resp_valid ? fifo_err[rd_ptr]  : 1'b0;
    assign resp_tag   = resp_valid ? fifo_tag[rd_ptr]  : '0;

`ifdef BANK_RESPONDER_STATS_EN
    logic [31:0] cnt_rd;
    logic [31:0] cnt_wr;
    logic [31:0] cnt_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_err <= '0;
        end else if (accept) begin
            if (!in_range) begin
                if (cnt_err != '1) cnt_err <= cnt_err + 32'd1;
            end else if (req_wr) begin
                if (cnt_wr != '1) cnt_wr <= cnt_wr + 32'd1;
            end else begin
                if (cnt_rd != '1) cnt_rd <= cnt_rd + 32'd1;
            end
        end
    end

    assign stat_rd  = cnt_rd;
    assign stat_wr  = cnt_wr;
    assign stat_err = cnt_err;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_bank_responder.sv
// Directed bench for bank_responder (BANK_ID=2, RD_LATENCY=2, FIFO_DEPTH=4).
// Expected values are hand-derived; bank 2 covers global addresses 52430..78644.
module tb_bank_responder;

    localparam int DW = 17;
    localparam int AW = 17;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_wr;
    logic          resp_err;
    logic [TW-1:0] resp_tag;
    logic [31:0]   stat_rd;
    logic [31:0]   stat_wr;
    logic [31:0]   stat_err;

    int checks = 0;
    int errors = 0;
    int acc;

    always #5 clk = ~clk;

    bank_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BANKS(5),
        .BANK_ID(2),
        .REQUESTERS(6),
        .RD_LATENCY(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_tag(req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_wr(resp_wr),
        .resp_err(resp_err),
        .resp_tag(resp_tag),
        .stat_rd(stat_rd),
        .stat_wr(stat_wr),
        .stat_err(stat_err)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input int addr, input int wdata, input int tag);
        req_valid = v;
        req_wr    = wr;
        req_addr  = AW'(addr);
        req_wdata = DW'(wdata);
        req_tag   = TW'(tag);
    endtask

    task automatic expect_resp(input string name, input logic wr, input logic err, input int tag, input int data);
        check(name, 64'({resp_valid, resp_wr, resp_err, resp_tag, resp_data}),
              64'({1'b1, wr, err, TW'(tag), DW'(data)}));
    endtask

    function automatic int wd(input int j);
        return (j * 5003 + 7) & 'h1FFFF;
    endfunction

    function automatic int wa(input int j);
        return (j == 9) ? 78644 : 52431 + j;
    endfunction

    initial begin
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        drive(0, 0, 0, 0, 0);

        // reset behaviour
        tick();
        check("rst_ready_low", 64'(req_ready), 64'(0));
        check("rst_resp_zero", 64'({resp_valid, resp_wr, resp_err, resp_tag, resp_data}), 64'(0));
        tick();
        tick();
        check("rst_stats_zero", 64'(stat_rd | stat_wr | stat_err), 64'(0));
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 64'(req_ready), 64'(1));

        // write then read same address on consecutive cycles
        drive(1, 1, 52430, 'h1ABCD, 1);
        tick();
        drive(1, 0, 52430, 0, 2);
        tick();
        drive(0, 0, 0, 0, 0);
        check("no_early_resp", 64'(resp_valid), 64'(0));
        tick();
        expect_resp("wr_resp", 1'b1, 1'b0, 1, 0);
        tick();
        expect_resp("rd_after_wr", 1'b0, 1'b0, 2, 'h1ABCD);
        tick();
        check("idle_after_rd", 64'(resp_valid), 64'(0));

        // out-of-range accesses; 85198 would alias to local index 0 if not blocked
        drive(1, 0, 52429, 0, 3);
        tick();
        drive(1, 0, 78645, 0, 4);
        tick();
        drive(1, 1, 85198, 'h00555, 5);
        tick();
        expect_resp("err_below", 1'b0, 1'b1, 3, 0);
        drive(1, 0, 52430, 0, 0);
        tick();
        expect_resp("err_above", 1'b0, 1'b1, 4, 0);
        drive(0, 0, 0, 0, 0);
        tick();
        expect_resp("err_write", 1'b1, 1'b1, 5, 0);
        tick();
        expect_resp("mem_unchanged", 1'b0, 1'b0, 0, 'h1ABCD);
        tick();
        check("idle_after_err", 64'(resp_valid), 64'(0));

        // 20 alternating write/read at full rate, including the last bank word
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) drive(1, 1, wa(k / 2), wd(k / 2), k % 6);
            else            drive(1, 0, wa(k / 2), 0, k % 6);
            #1;
            check("stream_ready", 64'(req_ready), 64'(1));
            tick();
            if (k >= 2) begin
                expect_resp("stream_resp", ((k - 2) % 2 == 0), 1'b0, (k - 2) % 6,
                            ((k - 2) % 2 == 0) ? 0 : wd((k - 2) / 2));
            end
        end
        drive(0, 0, 0, 0, 0);
        for (int k = 20; k < 22; k++) begin
            tick();
            expect_resp("stream_drain", ((k - 2) % 2 == 0), 1'b0, (k - 2) % 6,
                        ((k - 2) % 2 == 0) ? 0 : wd((k - 2) / 2));
        end
        tick();
        check("stream_empty", 64'(resp_valid), 64'(0));

        // backpressure: exactly FIFO_DEPTH accepted with resp_ready low
        resp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1, 0, 52430, 0, t);
            #1;
            check("bp_ready_open", 64'(req_ready), 64'(1));
            tick();
        end
        drive(1, 0, 52430, 0, 4);
        #1;
        check("bp_ready_full", 64'(req_ready), 64'(0));
        tick();
        tick();
        tick();
        check("bp_still_full", 64'(req_ready), 64'(0));
        expect_resp("bp_head_stable", 1'b0, 1'b0, 0, 'h1ABCD);
        resp_ready = 1'b1;
        #1;
        check("bp_ready_on_pop", 64'(req_ready), 64'(1));
        tick();
        drive(0, 0, 0, 0, 0);
        for (int t = 1; t < 5; t++) begin
            expect_resp("bp_order", 1'b0, 1'b0, t, 'h1ABCD);
            tick();
        end
        check("bp_empty", 64'(resp_valid), 64'(0));

        // reset with three responses outstanding
        resp_ready = 1'b0;
        for (int t = 1; t < 4; t++) begin
            drive(1, 0, 52431, 0, t);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        check("mid_rst_resp", 64'({resp_valid, resp_wr, resp_err, resp_tag, resp_data}), 64'(0));
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("no_stale_resp", 64'(resp_valid), 64'(0));
        end
        drive(1, 0, 52431, 0, 5);
        tick();
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        expect_resp("mem_retained", 1'b0, 1'b0, 5, wd(0));
        tick();
        resp_ready = 1'b0;
        acc = 0;
        drive(1, 0, 52430, 0, 1);
        for (int t = 0; t < 6; t++) begin
            #1;
            if (req_ready) acc++;
            tick();
        end
        check("credits_cleared", 64'(acc), 64'(4));
        drive(0, 0, 0, 0, 0);
        resp_ready = 1'b1;
        for (int t = 0; t < 6; t++) tick();
        check("credits_drained", 64'(resp_valid), 64'(0));

        // statistics: 2 writes, 3 reads, 1 error after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("stat_clear", 64'(stat_rd | stat_wr | stat_err), 64'(0));
        drive(1, 1, 52440, 11, 0);
        tick();
        drive(1, 1, 52441, 22, 1);
        tick();
        drive(1, 0, 52430, 0, 2);
        tick();
        drive(1, 0, 52440, 0, 3);
        tick();
        drive(1, 0, 52441, 0, 4);
        tick();
        drive(1, 0, 100000, 0, 5);
        tick();
        drive(0, 0, 0, 0, 0);
`ifdef BANK_RESPONDER_STATS_EN
        check("stat_rd", 64'(stat_rd), 64'(3));
        check("stat_wr", 64'(stat_wr), 64'(2));
        check("stat_err", 64'(stat_err), 64'(1));
`else
        check("stat_rd", 64'(stat_rd), 64'(0));
        check("stat_wr", 64'(stat_wr), 64'(0));
        check("stat_err", 64'(stat_err), 64'(0));
`endif
        for (int t = 0; t < 4; t++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
